// File: rtl/div_cell.sv
// One restoring-divide stage: retires one quotient bit (MSB first) and
// registers the shifted dividend, divisor, partial quotient/remainder and
// zero flag for the next stage.
module div_cell #(
    parameter int N = 8,
    parameter int M = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         prev_vld,
    input  logic [N-1:0] prev_dvd,
    input  logic [M-1:0] prev_dvs,
    input  logic [N-1:0] prev_quo,
    input  logic [M-1:0] prev_rem,
    input  logic         prev_zero,
    output logic         vld,
    output logic [N-1:0] dvd,
    output logic [M-1:0] dvs,
    output logic [N-1:0] quo,
    output logic [M-1:0] rem,
    output logic         zero
);

    // The dividend is kept left-aligned: its MSB is always the next bit to
    // bring down, so every stage is identical and needs no index parameter.
    logic [M:0]   trial;
    logic [M:0]   diff;
    logic         q_bit;
    logic [N:0]   quo_ext;
    logic [N-1:0] dvd_nxt;
    logic [M-1:0] rem_nxt;

    // Dropped bits: diff MSB is 0 whenever it is used, quotient MSB falls off.
    logic unused_bits;
    assign unused_bits = diff[M] ^ quo_ext[N];

    // Compare/subtract at M+1 bits and shift the quotient bit in.
    always_comb begin
        trial   = {prev_rem, prev_dvd[N-1]};
        diff    = trial - {1'b0, prev_dvs};
        q_bit   = (trial >= {1'b0, prev_dvs});
        rem_nxt = q_bit ? diff[M-1:0] : trial[M-1:0];
        quo_ext = {prev_quo, q_bit};
        dvd_nxt = prev_dvd << 1;
    end

    // Valid follows the pipe every cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) vld <= 1'b0;
        else     vld <= prev_vld;
    end

    // Payload loads only behind a valid, so bubbles leave it untouched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dvd  <= '0;
            dvs  <= '0;
            quo  <= '0;
            rem  <= '0;
            zero <= 1'b0;
        end else if (prev_vld) begin
            dvd  <= dvd_nxt;
            dvs  <= prev_dvs;
            quo  <= quo_ext[N-1:0];
            rem  <= rem_nxt;
            zero <= prev_zero;
        end
    end

endmodule

// File: rtl/pipeline_divide.sv
// Pipelined restoring unsigned divider: N stages, one quotient bit per
// stage, one operand pair accepted per cycle, no backpressure.
module pipeline_divide #(
    parameter int N = 8,
    parameter int M = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         data_ready,
    input  logic [N-1:0] dividend,
    input  logic [M-1:0] divisor,
    output logic         result_ready,
    output logic [N-1:0] quotient,
    output logic [M-1:0] remainder,
    output logic         div_zero
);

    // Index 0 is the port side, index k+1 is the output of stage k.
    logic [N:0]        vld_pipe;
    logic [N:0][N-1:0] dvd_pipe;
    logic [N:0][M-1:0] dvs_pipe;
    logic [N:0][N-1:0] quo_pipe;
    logic [N:0][M-1:0] rem_pipe;
    logic [N:0]        zero_pipe;

    // Stage 0 starts with an empty quotient and remainder.
    assign vld_pipe[0]  = data_ready;
    assign dvd_pipe[0]  = dividend;
    assign dvs_pipe[0]  = divisor;
    assign quo_pipe[0]  = '0;
    assign rem_pipe[0]  = '0;
    assign zero_pipe[0] = (divisor == '0);

    for (genvar k = 0; k < N; k++) begin : g_stage
        div_cell #(.N(N), .M(M)) u_cell (
            .clk       (clk),
            .rst       (rst),
            .prev_vld  (vld_pipe[k]),
            .prev_dvd  (dvd_pipe[k]),
            .prev_dvs  (dvs_pipe[k]),
            .prev_quo  (quo_pipe[k]),
            .prev_rem  (rem_pipe[k]),
            .prev_zero (zero_pipe[k]),
            .vld       (vld_pipe[k+1]),
            .dvd       (dvd_pipe[k+1]),
            .dvs       (dvs_pipe[k+1]),
            .quo       (quo_pipe[k+1]),
            .rem       (rem_pipe[k+1]),
            .zero      (zero_pipe[k+1])
        );
    end

    // Last stage's dividend/divisor copies have no consumer.
    logic unused_tail;
    assign unused_tail = ^{dvd_pipe[N], dvs_pipe[N]};

    // Outputs come straight from the final stage registers.
    assign result_ready = vld_pipe[N];
    assign quotient     = quo_pipe[N];
    assign remainder    = rem_pipe[N];
    assign div_zero     = zero_pipe[N];

endmodule

// File: tb/tb_pipeline_divide.sv
module tb_pipeline_divide;
    localparam int N = 8;
    localparam int M = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         data_ready = 1'b0;
    logic [N-1:0] dividend = '0;
    logic [M-1:0] divisor = '0;
    logic         result_ready;
    logic [N-1:0] quotient;
    logic [M-1:0] remainder;
    logic         div_zero;

    int checks = 0;
    int failures = 0;
    int rr_count = 0;

    pipeline_divide #(.N(N), .M(M)) dut (
        .clk          (clk),
        .rst          (rst),
        .data_ready   (data_ready),
        .dividend     (dividend),
        .divisor      (divisor),
        .result_ready (result_ready),
        .quotient     (quotient),
        .remainder    (remainder),
        .div_zero     (div_zero)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    typedef struct packed {
        logic         v;
        logic [N-1:0] q;
        logic [M-1:0] r;
        logic         z;
    } res_t;

    function automatic res_t ref_div(logic [N-1:0] a, logic [M-1:0] b);
        res_t x;
        x.v = 1'b1;
        if (b == '0) begin
            x.q = '1;
            x.r = a[M-1:0];
            x.z = 1'b1;
        end else begin
            x.q = a / N'(b);
            x.r = M'(a % N'(b));
            x.z = 1'b0;
        end
        return x;
    endfunction

    // Delay line of N: a result sampled at edge E sits in slot N-1 after E+N-1.
    res_t mpipe[N];
    res_t held = '0;

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N; i++) mpipe[i] <= '0;
            held <= '0;
        end else begin
            for (int i = N - 1; i > 0; i--) mpipe[i] <= mpipe[i-1];
            mpipe[0] <= data_ready ? ref_div(dividend, divisor) : '0;
            if (mpipe[N-2].v) held <= mpipe[N-2];
            else              held.v <= 1'b0;
        end
    end

    // Continuous comparison against the model on every falling edge.
    always @(negedge clk) begin
        res_t want;
        want = rst ? '0 : held;
        checks++;
        if ({result_ready, quotient, remainder, div_zero} !== want) begin
            failures++;
            $display("FAIL model t=%0t got rr=%0b q=%0d r=%0d z=%0b want rr=%0b q=%0d r=%0d z=%0b",
                     $time, result_ready, quotient, remainder, div_zero,
                     want.v, want.q, want.r, want.z);
        end
        if (result_ready === 1'b1) rr_count++;
    end

    // ---------------- helpers ----------------
    task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d want=%0d", name, got, exp);
        end
    endtask

    // Present one pair for exactly one sample edge; returns at edge+#1.
    task automatic issue(logic [N-1:0] a, logic [M-1:0] b);
        data_ready = 1'b1;
        dividend   = a;
        divisor    = b;
        @(posedge clk);
        #1 data_ready = 1'b0;
    endtask

    typedef struct {
        logic [N-1:0] a;
        logic [M-1:0] b;
        logic [N-1:0] q;
        logic [M-1:0] r;
        logic         z;
    } vec_t;

    vec_t vecs[6];

    // Single pulse: nothing one cycle early, the result exactly N cycles on.
    task automatic check_vec(vec_t v);
        issue(v.a, v.b);
        repeat (N - 2) @(posedge clk);
        @(negedge clk);
        chk("early_rr", 32'(result_ready), 0);
        @(posedge clk);
        @(negedge clk);
        chk("vec_rr", 32'(result_ready), 1);
        chk("vec_q", 32'(quotient), 32'(v.q));
        chk("vec_r", 32'(remainder), 32'(v.r));
        chk("vec_z", 32'(div_zero), 32'(v.z));
        @(posedge clk);
        #1;
    endtask

    int base;

    initial begin
        vecs[0] = '{8'd100, 4'd7,  8'd14,  4'd2,  1'b0};
        vecs[1] = '{8'd255, 4'd15, 8'd17,  4'd0,  1'b0};
        vecs[2] = '{8'd5,   4'd9,  8'd0,   4'd5,  1'b0};
        vecs[3] = '{8'd13,  4'd0,  8'd255, 4'd13, 1'b1};
        vecs[4] = '{8'd0,   4'd1,  8'd0,   4'd0,  1'b0};
        vecs[5] = '{8'd255, 4'd1,  8'd255, 4'd0,  1'b0};

        // data_ready during reset is ignored; outputs read 0.
        data_ready = 1'b1;
        dividend   = 8'd100;
        divisor    = 4'd7;
        @(negedge clk);
        chk("rst_out", 32'({result_ready, quotient, remainder, div_zero}), 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        data_ready = 1'b0;
        base = rr_count;
        repeat (12) @(posedge clk);
        #1 chk("rst_ignored", 32'(rr_count - base), 0);

        // Directed table.
        foreach (vecs[i]) check_vec(vecs[i]);

        // Back-to-back directed pair.
        issue(8'd255, 4'd15);
        issue(8'd5, 4'd9);
        repeat (N - 2) @(posedge clk);
        @(negedge clk);
        chk("b2b_rr0", 32'(result_ready), 1);
        chk("b2b_q0", 32'(quotient), 17);
        chk("b2b_r0", 32'(remainder), 0);
        @(posedge clk);
        @(negedge clk);
        chk("b2b_rr1", 32'(result_ready), 1);
        chk("b2b_q1", 32'(quotient), 0);
        chk("b2b_r1", 32'(remainder), 5);
        @(posedge clk);
        @(negedge clk);
        chk("b2b_end", 32'(result_ready), 0);
        @(posedge clk);
        #1;

        // 16 random pairs back to back.
        base = rr_count;
        for (int i = 0; i < 16; i++) issue(N'($urandom), M'($urandom));
        repeat (N + 4) @(posedge clk);
        #1 chk("burst_count", 32'(rr_count - base), 16);

        // Reset mid-flight discards 200/3.
        base = rr_count;
        issue(8'd200, 4'd3);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("midrst_out", 32'({result_ready, quotient, remainder, div_zero}), 0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (N + 4) @(posedge clk);
        #1 chk("midrst_drop", 32'(rr_count - base), 0);
        check_vec('{8'd200, 4'd3, 8'd66, 4'd2, 1'b0});

        // Alternating valid with bubbles; model checks hold behaviour.
        base = rr_count;
        for (int i = 0; i < 20; i++) begin
            data_ready = (i % 2 == 0);
            dividend   = N'($urandom);
            divisor    = M'($urandom_range(0, 15));
            @(posedge clk);
            #1;
        end
        data_ready = 1'b0;
        repeat (N + 4) @(posedge clk);
        #1 chk("alt_count", 32'(rr_count - base), 10);

        // Longer random mix of valid and idle cycles.
        base = rr_count;
        for (int i = 0; i < 200; i++) begin
            data_ready = 1'($urandom);
            dividend   = N'($urandom);
            divisor    = M'($urandom);
            @(posedge clk);
            #1;
        end
        data_ready = 1'b0;
        repeat (N + 4) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipeline_divide.md
# pipeline_divide

Pipelined restoring unsigned divider, the inverse operation of the team's pipelined shift-and-add multiplier. It retires one quotient bit per stage, MSB first, over N registered stages, and accepts a new operand pair every cycle. It has no backpressure. It sits beside the multiplier in the arithmetic datapath and uses the same data_ready/result_ready valid-only handshake.

## Interface
Parameters:
- N, default 8: dividend and quotient width; also the pipeline depth.
- M, default 4: divisor and remainder width (M ≥ 1, M ≤ N).

Ports:
- clk  in  1  sole clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous and active-high.
- data_ready  in  1  operand valid; operands are sampled on every clk edge where it is 1.
- dividend  in  N  unsigned dividend.
- divisor  in  M  unsigned divisor.
- result_ready  out  1  result valid, 1 for exactly one cycle per accepted operand pair.
- quotient  out  N  unsigned quotient.
- remainder  out  M  unsigned remainder.
- div_zero  out  1  the result came from a divisor of 0.

## Operation
- Stage k (0..N-1) holds a valid bit and a payload:
  - remaining dividend bits
  - divisor (M bits)
  - partial quotient (N bits)
  - partial remainder r (M bits)
  - zero flag
- Stage 0 takes its input from the ports, with r = 0 and partial quotient = 0.
- Per-stage step:
  - t = {r, next dividend bit} (M+1 bits); the next dividend bit is dividend[N-1-k].
  - If t ≥ {1'b0, divisor}: r' = (t − divisor)[M-1:0] and the quotient bit is 1.
  - Otherwise: r' = t[M-1:0] and the quotient bit is 0.
  - The quotient bit shifts into the partial quotient LSB.
- Width rule: the subtraction is done at M+1 bits. The remainder register is M bits, which is lossless because the remainder is always less than a nonzero divisor.
- Divisor = 0:
  - The algorithm runs unmodified. Every compare passes, so quotient = all ones and remainder = dividend[M-1:0].
  - div_zero = 1. It is computed at stage 0 as (divisor == 0) and piped along with the data.
- A stage's payload registers load only when the incoming valid is 1. Its valid register loads every cycle.
- Outputs are driven directly from the stage N-1 registers. Between results they hold the last result.
- There is no stall and no flush input. Every accepted pair emerges in order.

## Timing
- Latency is N cycles. A pair sampled at edge E produces result_ready = 1 in the cycle after edge E+N-1, i.e. visible N cycles after the sample edge.
- Throughput is one pair per cycle. Back-to-back data_ready produces back-to-back result_ready.
- Idle cycles (data_ready = 0) propagate as result_ready = 0 bubbles, with the same N-cycle delay.
- Reset values: result_ready = 0, quotient = 0, remainder = 0, div_zero = 0. All stage valid and payload registers are 0.
- Reset mid-operation: every in-flight pair is discarded, and no result_ready occurs for any of them. After rst deasserts, the first data_ready is sampled on the first clk edge.
- data_ready asserted while rst = 1 is ignored.

## Structure
- No shared package; all widths derive from N and M.
- One sub-module, div_cell, implements one stage: compare/subtract, quotient shift, and valid/payload registers.
- pipeline_divide instantiates N copies of div_cell in a generate loop, with stage 0 fed from the ports. div_cell carries the N and M parameters.

## Test plan
Each scenario uses N=8, M=4.
- 100 / 7, single pulse → N=8 cycles later, one result_ready pulse with quotient = 14, remainder = 2, div_zero = 0.
- 255 / 15 and 5 / 9 on consecutive cycles → consecutive results: (17, 0) then (0, 5).
- 13 / 0 → quotient = 255, remainder = 13, div_zero = 1.
- 16 pairs on 16 consecutive cycles, compared against a reference model → 16 consecutive result_ready cycles, in order, all matching.
- rst pulsed 3 cycles after issuing 200 / 3 → no result_ready for that pair. A new 200 / 3 issued after reset → (66, 2) after 8 cycles. All outputs read 0 during reset.
- Alternating data_ready 1/0 with random operands → result_ready shows the same pattern delayed by 8 cycles, and outputs hold their values during the bubbles.
